shift_register_ctrl: RTL and testbench

// Sequencer for one N-bit shift_register (D = shift_en&prev | Par_load&Par_in; no hold path).
// TX: loads a parallel word and clocks it out MSB-index-last (Par_out[N-1] first).
// RX: clocks N serial bits in and captures the parallel word.

---
 rtl/shift_register_ctrl_if.sv | 36 +++
 rtl/shift_register_ctrl.sv | 128 ++++++++++++
 tb/tb_shift_register_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/shift_register_ctrl_if.sv
// Host and register-side signal bundle for shift_register_ctrl.
// The host/bench drives master; the controller uses slave.
interface shift_register_ctrl_if #(
    parameter int N = 8
);
    logic         start;
    logic         mode;
    logic [0:N-1] data_in;
    logic         rx_ser;
    logic         ready;
    logic         busy;
    logic         tx_bit;
    logic         tx_valid;
    logic [0:N-1] data_out;
    logic         done;

    // Controlled shift register connections
    logic [0:N-1] reg_par_out;
    logic         reg_ser_out;
    logic         reg_par_load;
    logic         reg_shift_en;
    logic [0:N-1] reg_par_in;
    logic         reg_ser_in;

    modport master (
        output start, mode, data_in, rx_ser, reg_par_out, reg_ser_out,
        input  ready, busy, tx_bit, tx_valid, data_out, done,
               reg_par_load, reg_shift_en, reg_par_in, reg_ser_in
    );

    modport slave (
        input  start, mode, data_in, rx_ser, reg_par_out, reg_ser_out,
        output ready, busy, tx_bit, tx_valid, data_out, done,
               reg_par_load, reg_shift_en, reg_par_in, reg_ser_in
    );
endinterface

// File: rtl/shift_register_ctrl.sv
// Sequencer for an N-bit load/shift register: TX serialises a word, RX deserialises one.
// state   | meaning
// IDLE    | ready, waiting for start
// LOAD    | TX only: parallel-load the latched word
// SHIFT   | N shift cycles, cnt 0..N-1
// CAPTURE | RX only: copy Par_out into data_out, done
// GAP     | GAP forced idle cycles before ready
module shift_register_ctrl #(
    parameter int   N    = 8,
    parameter int   GAP  = 2,
    parameter logic FILL = 1'b0
) (
    input logic                  Clk,
    input logic                  reset,
    shift_register_ctrl_if.slave bus
);

    localparam int CNT_MAX = (N > GAP) ? N : GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] SHIFT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'((GAP > 0) ? (GAP - 1) : 0);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_SHIFT   = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_GAP     = 3'd4;

    localparam logic [2:0] S_AFTER_FRAME = (GAP == 0) ? S_IDLE : S_GAP;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          mode_q;
    logic [0:N-1]  word_q;
    logic          done_q;
    logic [0:N-1]  data_out_q;
    logic          shift_last;
    logic          accept;

    assign shift_last = (state == S_SHIFT) && (cnt == SHIFT_LAST);
    assign accept     = (state == S_IDLE) && bus.start;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = bus.mode ? S_SHIFT : S_LOAD;
                    cnt_nxt   = '0;
                end
            end
            S_LOAD: begin
                state_nxt = S_SHIFT;
                cnt_nxt   = '0;
            end
            S_SHIFT: begin
                if (cnt == SHIFT_LAST) begin
                    state_nxt = mode_q ? S_CAPTURE : S_AFTER_FRAME;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_CAPTURE: begin
                state_nxt = S_AFTER_FRAME;
                cnt_nxt   = '0;
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            mode_q     <= 1'b0;
            word_q     <= '0;
            done_q     <= 1'b0;
            data_out_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                mode_q <= bus.mode;
                word_q <= bus.data_in;
            end
            // The cycle after the last shift is CAPTURE for RX and the first
            // post-frame cycle for TX, so one rule covers both done pulses.
            done_q <= shift_last;
            // Register self-clears at this edge; sample its pre-edge contents.
            if (state == S_CAPTURE) begin
                data_out_q <= bus.reg_par_out;
            end
        end
    end

    always_comb begin
        bus.ready        = (state == S_IDLE);
        bus.busy         = (state != S_IDLE);
        bus.reg_par_load = (state == S_LOAD);
        bus.reg_par_in   = (state == S_LOAD) ? word_q : '0;
        bus.reg_shift_en = (state == S_SHIFT);
        bus.reg_ser_in   = 1'b0;
        if (state == S_SHIFT) begin
            bus.reg_ser_in = mode_q ? bus.rx_ser : FILL;
        end
        bus.tx_valid = (state == S_SHIFT) && !mode_q;
        bus.tx_bit   = bus.tx_valid && bus.reg_ser_out;
        bus.done     = done_q;
        bus.data_out = data_out_q;
    end

endmodule

// File: tb/tb_shift_register_ctrl.sv
// Bench for shift_register_ctrl with a behavioural load/shift register attached.
module tb_shift_register_ctrl;
    localparam int N   = 8;
    localparam int GAP = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    logic [0:N-1] last_rx = '0;
    logic [0:N-1] sr;
    logic [0:N-1] seq;

    shift_register_ctrl_if #(.N(N)) bus ();

    shift_register_ctrl #(.N(N), .GAP(GAP), .FILL(1'b0)) dut (
        .Clk  (clk),
        .reset(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Controlled register: D = shift_en&prev | Par_load&Par_in, no hold path.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr <= '0;
        end else begin
            sr[0] <= (bus.reg_shift_en & bus.reg_ser_in) | (bus.reg_par_load & bus.reg_par_in[0]);
            for (int i = 1; i < N; i++)
                sr[i] <= (bus.reg_shift_en & sr[i-1]) | (bus.reg_par_load & bus.reg_par_in[i]);
        end
    end
    assign bus.reg_par_out = sr;
    assign bus.reg_ser_out = sr[N-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) chk("ctrl_exclusive", 32'(bus.reg_par_load & bus.reg_shift_en), 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame from accept to the next cycle where ready must be back.
    // Cycle c counts edges after the accepting edge.
    task automatic frame(input logic m, input logic [0:N-1] w, input logic [0:N-1] rxb,
                         input bit hold, input bit poke, output logic [0:N-1] txseq);
        int dones;
        int valids;
        int ready_low;
        logic [0:N-1] exp_rx;
        logic exp_valid;
        logic exp_bit;
        for (int k = 0; k < N; k++) exp_rx[N-1-k] = rxb[k];
        txseq = '0;
        dones = 0;
        valids = 0;
        ready_low = 0;
        chk("pre_ready", 32'(bus.ready), 32'd1);
        bus.start   = 1'b1;
        bus.mode    = m;
        bus.data_in = w;
        for (int c = 1; c <= N + 2 + GAP; c++) begin
            tick();
            if (!hold) bus.start = poke && (c == 5);
            bus.mode    = 1'($urandom);
            bus.data_in = N'($urandom);
            bus.rx_ser  = (m && c <= N) ? rxb[c-1] : 1'($urandom);
            exp_valid = !m && (c >= 2) && (c <= N + 1);
            exp_bit   = 1'b0;
            if (exp_valid) begin
                exp_bit = w[N-1-(c-2)];
                txseq[c-2] = bus.tx_bit;
            end
            chk("tx_valid", 32'(bus.tx_valid), 32'(exp_valid));
            chk("tx_bit", 32'(bus.tx_bit), 32'(exp_bit));
            chk("done", 32'(bus.done), 32'(c == (m ? N + 1 : N + 2)));
            chk("ready", 32'(bus.ready), 32'(c == N + 2 + GAP));
            chk("busy", 32'(bus.busy), 32'(c != N + 2 + GAP));
            if (m && c > N + 1) chk("data_out_new", 32'(bus.data_out), 32'(exp_rx));
            else                chk("data_out_held", 32'(bus.data_out), 32'(last_rx));
            if (!m) chk("ser_in_fill", 32'(bus.reg_ser_in), 32'd0);
            dones     += int'(bus.done);
            valids    += int'(bus.tx_valid);
            ready_low += int'(!bus.ready);
        end
        chk("done_count", 32'(dones), 32'd1);
        chk("valid_count", 32'(valids), m ? 32'd0 : 32'(N));
        chk("ready_low_cycles", 32'(ready_low), 32'(N + 1 + GAP));
        if (m) last_rx = exp_rx;
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.mode    = 1'b0;
        bus.data_in = '0;
        bus.rx_ser  = 1'b0;
        #1;
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_data_out", 32'(bus.data_out), 32'd0);
        chk("rst_par_load", 32'(bus.reg_par_load), 32'd0);
        chk("rst_shift_en", 32'(bus.reg_shift_en), 32'd0);
        #20;
        rst = 1'b1;
        tick();
        tick();

        // Directed TX word from the datasheet example
        frame(1'b0, 8'b1011_0010, 8'h00, 1'b0, 1'b0, seq);
        chk("tx_seq_example", 32'(seq), 32'(8'b0100_1101));

        // Directed RX bits 1,1,0,0,1,0,1,0
        frame(1'b1, 8'h5A, 8'b1100_1010, 1'b0, 1'b0, seq);
        chk("rx_word_example", 32'(bus.data_out), 32'(8'b0101_0011));

        // Back-to-back with start held high
        frame(1'b0, 8'hC3, 8'h00, 1'b1, 1'b0, seq);
        frame(1'b1, 8'h00, 8'h3C, 1'b1, 1'b0, seq);
        frame(1'b0, 8'h81, 8'h00, 1'b1, 1'b0, seq);
        bus.start = 1'b0;

        // start pulsed mid-SHIFT must not queue a second frame
        frame(1'b0, 8'h96, 8'h00, 1'b0, 1'b1, seq);
        for (int i = 0; i < N + 4; i++) begin
            tick();
            chk("poke_no_done", 32'(bus.done), 32'd0);
            chk("poke_idle", 32'(bus.ready), 32'd1);
        end

        // Randomized frames
        for (int f = 0; f < 10; f++) begin
            frame(1'($urandom), N'($urandom), N'($urandom), 1'($urandom), 1'($urandom), seq);
        end
        bus.start = 1'b0;
        tick();

        // Reset during SHIFT cnt=4 of a TX frame (after an RX left data_out nonzero)
        frame(1'b1, 8'h00, 8'b1011_0111, 1'b0, 1'b0, seq);
        bus.start   = 1'b1;
        bus.mode    = 1'b0;
        bus.data_in = 8'hFF;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("mid_shift_valid", 32'(bus.tx_valid), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_ready", 32'(bus.ready), 32'd1);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("abort_tx_bit", 32'(bus.tx_bit), 32'd0);
        chk("abort_shift_en", 32'(bus.reg_shift_en), 32'd0);
        chk("abort_ser_in", 32'(bus.reg_ser_in), 32'd0);
        chk("abort_par_in", 32'(bus.reg_par_in), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_data_out", 32'(bus.data_out), 32'd0);
        last_rx = '0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < N + 4; i++) begin
            tick();
            chk("post_abort_done", 32'(bus.done), 32'd0);
            chk("post_abort_ready", 32'(bus.ready), 32'd1);
        end

        // Controller still usable after the abort
        frame(1'b0, 8'h6B, 8'h00, 1'b0, 1'b0, seq);
        chk("tx_seq_after_abort", 32'(seq), 32'(8'b1101_0110));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
